spike_rate_meter: RTL and testbench

//  Downstream consumer of the LIF neuron's spike output. Counts spike rising

---
 rtl/snn_pkg.sv | 16 +
 rtl/spike_edge_det.sv | 25 ++
 rtl/spike_rate_meter.sv | 150 +++++++++++++++
 tb/tb_spike_rate_meter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-neuron datapath blocks.
package snn_pkg;

  // Default spike-count width, shared with the LIF top level.
  localparam int CNT_W_DEF = 8;

  // Default window-length width, shared with the LIF top level.
  localparam int WIN_W_DEF = 8;

  // Rate meter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1
  } srm_state_t;

endpackage

// File: rtl/spike_edge_det.sv
// Registered rising-edge detector for the neuron spike level.
// The rise output is combinational from the live input and the registered
// history, so an edge is reported in the same cycle the level goes high.
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic spike,
  output logic rise
);

  logic spike_q;

  // Keep one cycle of spike history; cleared on reset so a level that is
  // already high when reset releases still produces one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike;
    end
  end

  assign rise = spike & ~spike_q;

endmodule

// File: rtl/spike_rate_meter.sv
// Spike rate meter: counts rising edges of the neuron spike output over a
// window of enable ticks and hands the count out on a valid/ready port.
// A new result can only load when the output slot is empty or being
// consumed in the same cycle; otherwise it is dropped and flagged.
module spike_rate_meter
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter bit CONT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             spike_i,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_o,
  output logic             rate_valid_o,
  input  logic             rate_ready_i,
  output logic             sat_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  srm_state_t       state;
  srm_state_t       state_next;
  logic [WIN_W:0]   len_q;
  logic [WIN_W:0]   tick_cnt;
  logic [WIN_W:0]   len_ext;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_q;
  logic             sat_inc;
  logic             spike_edge;
  logic             in_count;
  logic             win_end;
  logic             can_load;

  spike_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (spike_i),
    .rise  (spike_edge)
  );

  assign in_count = (state == COUNT);
  assign busy_o   = in_count;

  // A zero length means the full 2**WIN_W ticks, hence the extra bit.
  assign len_ext = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}}
                                      : {1'b0, window_len};

  // A restart takes priority over a window end landing in the same cycle.
  assign win_end  = in_count & tick & ~start & (tick_cnt == (len_q - 1'b1));
  assign can_load = ~rate_valid_o | rate_ready_i;

  // Saturating count including this cycle's edge, and the sticky sat flag
  // that goes with it; these are what a closing window reports.
  always_comb begin
    cnt_inc = spk_cnt;
    sat_inc = sat_q;
    if (spike_edge) begin
      if (spk_cnt == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        cnt_inc = spk_cnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start always (re)enters COUNT; a window end either rolls
  // straight into the next window or parks in IDLE.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = COUNT;
    end else if (win_end) begin
      state_next = CONT ? COUNT : IDLE;
    end
  end

  // Window length, tick counter and spike counter; an edge seen in the
  // start cycle already belongs to the new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      tick_cnt <= '0;
      spk_cnt  <= '0;
      sat_q    <= 1'b0;
    end else if (start) begin
      len_q    <= len_ext;
      tick_cnt <= '0;
      spk_cnt  <= CNT_W'(spike_edge);
      sat_q    <= 1'b0;
    end else if (in_count) begin
      if (win_end) begin
        tick_cnt <= '0;
        spk_cnt  <= '0;
        sat_q    <= 1'b0;
      end else begin
        if (tick) begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        spk_cnt <= cnt_inc;
        sat_q   <= sat_inc;
      end
    end
  end

  // Output slot: load a finished window when there is room, otherwise
  // keep the held sample and let valid fall once it has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_o       <= '0;
      sat_o        <= 1'b0;
      rate_valid_o <= 1'b0;
    end else if (win_end && can_load) begin
      rate_o       <= cnt_inc;
      sat_o        <= sat_inc;
      rate_valid_o <= 1'b1;
    end else if (rate_valid_o && rate_ready_i) begin
      rate_valid_o <= 1'b0;
    end
  end

  // Sticky overrun flag: set by a dropped window, cleared by a start
  // issued from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (start && !in_count) begin
      overrun_o <= 1'b0;
    end else if (win_end && !can_load) begin
      overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_rate_meter.sv
// Bench for spike_rate_meter: three instances (one-shot 8-bit, continuous
// 8-bit, one-shot 4-bit) share one stimulus stream and are each compared
// every cycle against a window-level rate model.
module tb_spike_rate_meter;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       spike_i;
  logic       start;
  logic [7:0] window_len;
  logic       rate_ready_i;

  logic [7:0] rate [3];
  logic [3:0] rate_n;
  logic [2:0] valid;
  logic [2:0] sat;
  logic [2:0] ovr;
  logic [2:0] busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  spike_rate_meter #(.CNT_W(8), .WIN_W(8), .CONT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike_i(spike_i), .start(start),
    .window_len(window_len), .rate_o(rate[0]), .rate_valid_o(valid[0]),
    .rate_ready_i(rate_ready_i), .sat_o(sat[0]), .overrun_o(ovr[0]),
    .busy_o(busy[0])
  );

  spike_rate_meter #(.CNT_W(8), .WIN_W(8), .CONT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike_i(spike_i), .start(start),
    .window_len(window_len), .rate_o(rate[1]), .rate_valid_o(valid[1]),
    .rate_ready_i(rate_ready_i), .sat_o(sat[1]), .overrun_o(ovr[1]),
    .busy_o(busy[1])
  );

  spike_rate_meter #(.CNT_W(4), .WIN_W(8), .CONT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike_i(spike_i), .start(start),
    .window_len(window_len), .rate_o(rate_n), .rate_valid_o(valid[2]),
    .rate_ready_i(rate_ready_i), .sat_o(sat[2]), .overrun_o(ovr[2]),
    .busy_o(busy[2])
  );

  assign rate[2] = {4'd0, rate_n};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state per instance: whether a window is open, its length, ticks
  // seen, edges counted, and the one-deep output slot.
  int cnt_max [3] = '{255, 255, 15};
  bit cont_p  [3] = '{1'b0, 1'b1, 1'b0};
  bit m_active [3];
  int m_len    [3];
  int m_ticks  [3];
  int m_count  [3];
  bit m_sat    [3];
  int m_rate   [3];
  bit m_valid  [3];
  bit m_rsat   [3];
  bit m_ovr    [3];
  bit m_prev;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit t, input bit s, input bit st);
    @(negedge clk);
    #2;
    tick    = t;
    spike_i = s;
    start   = st;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Window-level model: count edges, close the window after len ticks,
  // and push the result into a one-entry slot that may be full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_active[i] = 0; m_len[i] = 0; m_ticks[i] = 0; m_count[i] = 0;
        m_sat[i] = 0; m_rate[i] = 0; m_valid[i] = 0; m_rsat[i] = 0;
        m_ovr[i] = 0;
      end
    end else begin
      bit e;
      e = spike_i & ~m_prev;
      m_prev = spike_i;
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i] && rate_ready_i) m_valid[i] = 0;
        if (start) begin
          if (!m_active[i]) m_ovr[i] = 0;
          m_active[i] = 1;
          m_len[i]    = (window_len == 0) ? 256 : int'(window_len);
          m_ticks[i]  = 0;
          m_count[i]  = e ? 1 : 0;
          m_sat[i]    = 0;
        end else if (m_active[i]) begin
          if (e) begin
            if (m_count[i] == cnt_max[i]) m_sat[i] = 1;
            else m_count[i]++;
          end
          if (tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == m_len[i]) begin
              if (!m_valid[i]) begin
                m_rate[i]  = m_count[i];
                m_rsat[i]  = m_sat[i];
                m_valid[i] = 1;
              end else begin
                m_ovr[i] = 1;
              end
              m_ticks[i]  = 0;
              m_count[i]  = 0;
              m_sat[i]    = 0;
              m_active[i] = cont_p[i];
            end
          end
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("rate%0d", i), 32'(rate[i]), 32'(m_rate[i]));
        checkOutput($sformatf("valid%0d", i), 32'(valid[i]), 32'(m_valid[i]));
        checkOutput($sformatf("sat%0d", i), 32'(sat[i]), 32'(m_rsat[i]));
        checkOutput($sformatf("ovr%0d", i), 32'(ovr[i]), 32'(m_ovr[i]));
        checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_active[i]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; spike_i = 1'b0; start = 1'b0;
    window_len = 8'd0; rate_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    checkOutput("reset_valid0", 32'(valid[0]), 32'd0);
    checkOutput("reset_busy1", 32'(busy[1]), 32'd0);
    checkOutput("reset_rate2", 32'(rate[2]), 32'd0);
    check_en = 1;

    // Three short spikes between ticks, four-tick one-shot window.
    window_len = 8'd4;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0); applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0); applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0); applyStimulus(1, 0, 0);
    settle();
    checkOutput("s1_busy_before_end", 32'(busy[0]), 32'd1);
    checkOutput("s1_valid_before_end", 32'(valid[0]), 32'd0);
    applyStimulus(1, 0, 0);
    settle();
    checkOutput("s1_rate", 32'(rate[0]), 32'd3);
    checkOutput("s1_valid", 32'(valid[0]), 32'd1);
    checkOutput("s1_busy_after", 32'(busy[0]), 32'd0);
    applyStimulus(0, 0, 0); applyStimulus(0, 0, 0);

    // Spike held high across the whole ten-tick window gives one edge.
    window_len = 8'd10;
    applyStimulus(0, 0, 1);
    for (int k = 0; k < 10; k++) applyStimulus(1, 1, 0);
    settle();
    checkOutput("s2_rate", 32'(rate[0]), 32'd1);
    applyStimulus(0, 0, 0); applyStimulus(0, 0, 0);

    // Twenty edges in a one-tick window: the 4-bit instance saturates.
    window_len = 8'd1;
    applyStimulus(0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
    end
    applyStimulus(1, 0, 0);
    settle();
    checkOutput("s3_rate_w8", 32'(rate[0]), 32'd20);
    checkOutput("s3_sat_w8", 32'(sat[0]), 32'd0);
    checkOutput("s3_rate_w4", 32'(rate[2]), 32'd15);
    checkOutput("s3_sat_w4", 32'(sat[2]), 32'd1);
    applyStimulus(0, 0, 0); applyStimulus(0, 0, 0);

    // Stalled consumer: held sample survives, later windows overrun.
    window_len = 8'd2;
    applyStimulus(0, 0, 0);
    rate_ready_i = 1'b0;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0);
    settle();
    checkOutput("s4_rate_cont", 32'(rate[1]), 32'd2);
    checkOutput("s4_valid_cont", 32'(valid[1]), 32'd1);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0);
    settle();
    checkOutput("s4_ovr_cont", 32'(ovr[1]), 32'd1);
    checkOutput("s4_rate_held_cont", 32'(rate[1]), 32'd2);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0); applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0);
    settle();
    checkOutput("s4_ovr_oneshot", 32'(ovr[0]), 32'd1);
    checkOutput("s4_rate_held_oneshot", 32'(rate[0]), 32'd2);
    applyStimulus(0, 0, 1);
    settle();
    checkOutput("s4_ovr_cleared", 32'(ovr[0]), 32'd0);
    rate_ready_i = 1'b1;
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0); applyStimulus(0, 0, 0);

    // Edge on the ending tick closes into the old window only.
    window_len = 8'd2;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    settle();
    checkOutput("s5_rate_first", 32'(rate[1]), 32'd1);
    applyStimulus(1, 1, 0); applyStimulus(1, 1, 0);
    settle();
    checkOutput("s5_rate_second", 32'(rate[1]), 32'd0);
    checkOutput("s5_valid_second", 32'(valid[1]), 32'd1);
    applyStimulus(0, 0, 0); applyStimulus(0, 0, 0);

    // Asynchronous reset in the middle of a window.
    window_len = 8'd5;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 0); applyStimulus(0, 0, 0); applyStimulus(1, 0, 0);
    #5 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("arst_rate%0d", i), 32'(rate[i]), 32'd0);
      checkOutput($sformatf("arst_valid%0d", i), 32'(valid[i]), 32'd0);
      checkOutput($sformatf("arst_sat%0d", i), 32'(sat[i]), 32'd0);
      checkOutput($sformatf("arst_ovr%0d", i), 32'(ovr[i]), 32'd0);
      checkOutput($sformatf("arst_busy%0d", i), 32'(busy[i]), 32'd0);
    end
    tick = 1'b0; spike_i = 1'b0; start = 1'b0;
    #4 rst_n = 1'b1;

    // Zero length means 256 ticks.
    window_len = 8'd0;
    applyStimulus(0, 0, 1);
    for (int k = 0; k < 255; k++) applyStimulus(1, 0, 0);
    settle();
    checkOutput("len0_busy_255", 32'(busy[0]), 32'd1);
    checkOutput("len0_valid_255", 32'(valid[0]), 32'd0);
    applyStimulus(1, 0, 0);
    settle();
    checkOutput("len0_valid_256", 32'(valid[0]), 32'd1);
    checkOutput("len0_busy_256", 32'(busy[0]), 32'd0);
    applyStimulus(0, 0, 0); applyStimulus(0, 0, 0);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
